// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (Booth radix-2) / restoring divide sequencer for the execute stage.
// Optional build macro MULTDIV_DIV0_FASTPATH_EN: divide-by-zero completes without iterating.
module multdiv_sequencer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [4:0]  ALU_op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;
  logic        booth_bit;
  logic [31:0] mcand;
  logic        neg_quot;
  logic        div_zero;
  logic        div_ovf;

  logic        is_mul;
  logic        is_div;
  logic        accept;
  logic        last_iter;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] mcand_ext;
  logic [32:0] booth_sum;
  logic [32:0] booth_hi_next;
  logic [31:0] booth_lo_next;
  logic        mul_ovf;

  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_signed;

  assign is_mul    = (ALU_op == OP_MUL);
  assign is_div    = (ALU_op == OP_DIV);
  assign accept    = (state == IDLE) && start && (is_mul || is_div) && !flush;
  assign last_iter = (count == 6'd31);
  assign abs_a     = operandA[31] ? (32'd0 - operandA) : operandA;
  assign abs_b     = operandB[31] ? (32'd0 - operandB) : operandB;

  assign busy         = (state != IDLE);
  assign stall        = accept || (state == MUL) || (state == DIV);
  assign result_valid = (state == DONE) && !flush;

  // Booth step: P carries a 33rd guard bit so subtracting the most negative multiplicand cannot overflow.
  assign mcand_ext = {mcand[31], mcand};

  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], booth_bit})
      2'b01:   booth_sum = acc_hi + mcand_ext;
      2'b10:   booth_sum = acc_hi - mcand_ext;
      default: booth_sum = acc_hi;
    endcase
  end

  assign booth_hi_next = {booth_sum[32], booth_sum[32:1]};
  assign booth_lo_next = {booth_sum[0], acc_lo[31:1]};
  assign mul_ovf       = (booth_hi_next[31:0] != {32{booth_lo_next[31]}});

  // Restoring divide: remainder in acc_hi, dividend bits shift out of acc_lo as quotient bits shift in.
  assign rem_shift = {acc_hi[31:0], acc_lo[31]};
  assign trial     = rem_shift - {1'b0, mcand};

  always_comb begin
    rem_next = rem_shift;
    quo_next = {acc_lo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_next = trial;
      quo_next = {acc_lo[30:0], 1'b1};
    end
  end

  assign quo_signed = neg_quot ? (32'd0 - quo_next) : quo_next;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= 6'd0;
      acc_hi    <= 33'd0;
      acc_lo    <= 32'd0;
      booth_bit <= 1'b0;
      mcand     <= 32'd0;
      neg_quot  <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
      result    <= 32'd0;
      exception <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      count <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count     <= 6'd0;
            acc_hi    <= 33'd0;
            booth_bit <= 1'b0;
            if (is_mul) begin
              state  <= MUL;
              acc_lo <= operandB;
              mcand  <= operandA;
            end else begin
              state    <= DIV;
              acc_lo   <= abs_a;
              mcand    <= abs_b;
              neg_quot <= operandA[31] ^ operandB[31];
              div_zero <= (operandB == 32'd0);
              div_ovf  <= (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);
`ifdef MULTDIV_DIV0_FASTPATH_EN
              if (operandB == 32'd0) begin
                state     <= DONE;
                result    <= 32'd0;
                exception <= 1'b1;
              end
`endif
            end
          end
        end
        MUL: begin
          acc_hi    <= booth_hi_next;
          acc_lo    <= booth_lo_next;
          booth_bit <= acc_lo[0];
          count     <= count + 6'd1;
          if (last_iter) begin
            state     <= DONE;
            count     <= count;
            result    <= booth_lo_next;
            exception <= mul_ovf;
          end
        end
        DIV: begin
          acc_hi <= rem_next;
          acc_lo <= quo_next;
          count  <= count + 6'd1;
          if (last_iter) begin
            state <= DONE;
            count <= count;
            if (div_zero) begin
              result    <= 32'd0;
              exception <= 1'b1;
            end else if (div_ovf) begin
              result    <= 32'h8000_0000;
              exception <= 1'b1;
            end else begin
              result    <= quo_signed;
              exception <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed testbench for multdiv_sequencer: vector table for full operations plus abort/corner sequences.
module tb_multdiv_sequencer;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

`ifdef MULTDIV_DIV0_FASTPATH_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ALU_op = 5'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        exception;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  multdiv_sequencer dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .ALU_op(ALU_op),
    .operandA(operandA),
    .operandB(operandB),
    .flush(flush),
    .busy(busy),
    .stall(stall),
    .result(result),
    .result_valid(result_valid),
    .exception(exception)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic quietCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      start = 1'b0;
      flush = 1'b0;
      ALU_op = 5'd0;
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    nextCycle();
    start = 1'b1;
    ALU_op = op;
    operandA = a;
    operandB = b;
    #1;
    checkOutput({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int seen;
    int stall_cnt;
    seen = 0;
    stall_cnt = 0;
    issue(v.op, v.a, v.b, tag);
    for (int c = 1; c <= 40; c++) begin
      nextCycle();
      start = 1'b0;
      ALU_op = 5'd0;
      #1;
      if (result_valid) begin
        seen = c;
        break;
      end
      if (stall) stall_cnt++;
    end
    checkOutput({tag, "_latency"}, seen, v.lat);
    checkOutput({tag, "_result"}, result, v.res);
    checkOutput({tag, "_exception"}, {31'd0, exception}, {31'd0, v.exc});
    checkOutput({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_stall_cycles"}, stall_cnt, v.lat - 1);
    nextCycle();
    #1;
    checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_result_hold"}, result, v.res);
  endtask

  initial begin
    vecs[0]  = '{OP_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33};
    vecs[2]  = '{OP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, 1'b0, 33};
    vecs[3]  = '{OP_MUL, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33};
    vecs[4]  = '{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
    vecs[5]  = '{OP_MUL, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, 33};
    vecs[6]  = '{OP_DIV, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
    vecs[8]  = '{OP_DIV, 32'd5,          32'd0,         32'h0000_0000, 1'b1, DIV0_LAT};
    vecs[9]  = '{OP_DIV, 32'd100,        32'd7,         32'h0000_000E, 1'b0, 33};
    vecs[10] = '{OP_DIV, 32'd7,          32'hFFFF_FF9C, 32'h0000_0000, 1'b0, 33};
    vecs[11] = '{OP_DIV, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, 33};
    vecs[12] = '{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 33};
    vecs[13] = '{OP_MUL, 32'd0,          32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};

    // Reset state
    quietCycles(2);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("reset_exception", {31'd0, exception}, 32'd0);
    nextCycle();
    resetn = 1'b1;
    quietCycles(1);

    // Unrecognised opcode and flushed request are not accepted
    nextCycle();
    start = 1'b1;
    ALU_op = 5'b00001;
    #1;
    checkOutput("badop_stall", {31'd0, stall}, 32'd0);
    nextCycle();
    ALU_op = OP_MUL;
    flush = 1'b1;
    #1;
    checkOutput("badop_busy", {31'd0, busy}, 32'd0);
    checkOutput("flushreq_stall", {31'd0, stall}, 32'd0);
    nextCycle();
    start = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("flushreq_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Start while busy is ignored; flush during DONE suppresses the pulse
    issue(OP_MUL, 32'd3, 32'd4, "busyign");
    for (int c = 1; c <= 32; c++) begin
      nextCycle();
      start = (c == 5);
      ALU_op = (c == 5) ? OP_DIV : 5'd0;
      operandA = 32'd100;
      operandB = 32'd7;
    end
    nextCycle();
    start = 1'b0;
    ALU_op = 5'd0;
    flush = 1'b1;
    #1;
    checkOutput("doneflush_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("doneflush_busy", {31'd0, busy}, 32'd1);
    checkOutput("busyign_result", result, 32'd12);
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("doneflush_after_busy", {31'd0, busy}, 32'd0);
    checkOutput("doneflush_after_valid", {31'd0, result_valid}, 32'd0);

    // Start in DONE is ignored
    issue(OP_MUL, 32'd2, 32'd3, "donestart");
    quietCycles(32);
    nextCycle();
    start = 1'b1;
    ALU_op = OP_MUL;
    #1;
    checkOutput("donestart_valid", {31'd0, result_valid}, 32'd1);
    checkOutput("donestart_result", result, 32'd6);
    checkOutput("donestart_stall", {31'd0, stall}, 32'd0);
    nextCycle();
    start = 1'b0;
    ALU_op = 5'd0;
    #1;
    checkOutput("donestart_busy", {31'd0, busy}, 32'd0);

    // Flush mid-multiply at cycle 10, new multiply at cycle 12 completes at cycle 45
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, "midflush");
    quietCycles(9);
    nextCycle();
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("midflush_busy", {31'd0, busy}, 32'd0);
    checkOutput("midflush_stall", {31'd0, stall}, 32'd0);
    checkOutput("midflush_valid", {31'd0, result_valid}, 32'd0);
    applyStimulus('{OP_MUL, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFE2, 1'b0, 33}, "afterflush");

    // Reset mid-multiply at cycle 10
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, "midreset");
    quietCycles(9);
    nextCycle();
    resetn = 1'b0;
    nextCycle();
    resetn = 1'b1;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_stall", {31'd0, stall}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("midreset_exception", {31'd0, exception}, 32'd0);
    quietCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
